fwd_hazard_ctrl: RTL and testbench

Parametrised forwarding and hazard controller for the in-order integer pipeline. It tracks in-flight register writers from EX through FWD_DEPTH later stages in an internal shadow pipeline. For each of NSRC source operands of the instruction in ID, it computes a registered forward select that is presented when that instruction reaches EX. It also raises a combinational load-use stall and keeps a stall-cycle counter. It sits beside the ID/EX pipeline register; its fwd_sel outputs drive the EX operand muxes.

---
 rtl/fwd_hazard_ctrl.sv | 148 ++++++++++++++
 tb/tb_fwd_hazard_ctrl.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fwd_hazard_ctrl
// Description : Forwarding and load-use hazard controller for the in-order
//               integer pipeline. A shadow pipeline tracks in-flight register
//               writers from EX (slot 0) through FWD_DEPTH later stages. For
//               each source operand of the ID instruction, a forward select
//               is computed and registered so it is presented when that
//               instruction reaches EX. A combinational load-use stall and a
//               saturating stall-cycle counter are also provided.
// Ports       :
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   id_valid     in   valid instruction in ID
//   id_src       in   NSRC*AW source registers, operand i at [i*AW +: AW]
//   id_src_used  in   NSRC per-operand "reads a register" flags
//   id_rd        in   destination register of the ID instruction
//   id_regwrite  in   ID instruction writes id_rd
//   id_is_load   in   ID instruction is a load
//   pipe_hold    in   freeze the whole back-end
//   ex_flush     in   squash the instruction entering EX
//   fwd_sel      out  NSRC*SW selects for EX: 0 = regfile, k = stage k
//   stall_id     out  load-use stall (hold ID, insert bubble)
//   stall_cnt    out  saturating count of stall cycles
// Constraints : FWD_DEPTH >= 1, 0 <= LOAD_LAT < FWD_DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_hazard_ctrl #(
    parameter int  AW        = 5,
    parameter int  NSRC      = 2,
    parameter int  FWD_DEPTH = 2,
    parameter int  LOAD_LAT  = 1,
    localparam int SW        = $clog2(FWD_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 id_valid,
    input  logic [NSRC*AW-1:0]   id_src,
    input  logic [NSRC-1:0]      id_src_used,
    input  logic [AW-1:0]        id_rd,
    input  logic                 id_regwrite,
    input  logic                 id_is_load,
    input  logic                 pipe_hold,
    input  logic                 ex_flush,
    output logic [NSRC*SW-1:0]   fwd_sel,
    output logic                 stall_id,
    output logic [15:0]          stall_cnt
);

    localparam logic [15:0] C_CNT_MAX = 16'hFFFF;

    // Shadow pipeline: index 0 is EX, index FWD_DEPTH is the oldest stage.
    logic [FWD_DEPTH:0]          slot_v_q,  slot_v_d;
    logic [FWD_DEPTH:0]          slot_ld_q, slot_ld_d;
    logic [FWD_DEPTH:0][AW-1:0]  slot_rd_q, slot_rd_d;
    logic [NSRC*SW-1:0]          fwd_sel_q, fwd_sel_d;
    logic [15:0]                 stall_cnt_q, stall_cnt_d;

    logic [NSRC*SW-1:0]          w_id_sel;
    logic [NSRC-1:0]             w_load_use;
    logic                        w_issue;

    // ------------------------------------------------------------------------
    // Per-operand lookup against slots 0..FWD_DEPTH-1. The loop walks from
    // oldest to youngest so the youngest match overwrites older ones. The
    // oldest slot is never a forwarding source: the register file writes
    // through for it. Requiring src != 0 also excludes rd == 0 entries.
    // ------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
            logic [AW-1:0] w_src;
            logic [SW-1:0] w_sel;
            logic          w_ld;

            assign w_src = id_src[gi*AW +: AW];

            always_comb begin
                w_sel = '0;
                w_ld  = 1'b0;
                if (id_src_used[gi] && (w_src != '0)) begin
                    for (int j = FWD_DEPTH - 1; j >= 0; j--) begin
                        if (slot_v_q[j] && (slot_rd_q[j] == w_src)) begin
                            w_sel = SW'(j + 1);
                            // Load data is not yet available this close to EX.
                            w_ld  = slot_ld_q[j] && (j < LOAD_LAT);
                        end
                    end
                end
            end

            assign w_id_sel[gi*SW +: SW] = w_sel;
            assign w_load_use[gi]        = w_ld;
        end
    endgenerate

    assign stall_id = id_valid & (|w_load_use);
    assign w_issue  = id_valid & ~stall_id & ~ex_flush;

    // ------------------------------------------------------------------------
    // Next-state: everything holds while pipe_hold is set (ex_flush included).
    // ------------------------------------------------------------------------
    always_comb begin
        slot_v_d    = slot_v_q;
        slot_ld_d   = slot_ld_q;
        slot_rd_d   = slot_rd_q;
        fwd_sel_d   = fwd_sel_q;
        stall_cnt_d = stall_cnt_q;

        if (!pipe_hold) begin
            for (int k = FWD_DEPTH; k >= 1; k--) begin
                slot_v_d[k]  = slot_v_q[k-1];
                slot_ld_d[k] = slot_ld_q[k-1];
                slot_rd_d[k] = slot_rd_q[k-1];
            end

            // A stalled or flushed ID instruction becomes a bubble in EX.
            slot_v_d[0]  = w_issue & id_regwrite;
            slot_ld_d[0] = w_issue & id_is_load;
            slot_rd_d[0] = w_issue ? id_rd : '0;
            fwd_sel_d    = w_issue ? w_id_sel : '0;

            if (stall_id && (stall_cnt_q != C_CNT_MAX)) begin
                stall_cnt_d = stall_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_v_q    <= '0;
            slot_ld_q   <= '0;
            slot_rd_q   <= '0;
            fwd_sel_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            slot_v_q    <= slot_v_d;
            slot_ld_q   <= slot_ld_d;
            slot_rd_q   <= slot_rd_d;
            fwd_sel_q   <= fwd_sel_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fwd_sel   = fwd_sel_q;
    assign stall_cnt = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fwd_hazard_ctrl
// Description : Directed self-checking bench for fwd_hazard_ctrl with default
//               parameters (AW=5, NSRC=2, FWD_DEPTH=2, LOAD_LAT=1, SW=2).
//               fwd_sel layout: op0 at [1:0], op1 at [3:2].
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fwd_hazard_ctrl;

    localparam int AW   = 5;
    localparam int NSRC = 2;
    localparam int SW   = 2;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                id_valid;
    logic [NSRC*AW-1:0]  id_src;
    logic [NSRC-1:0]     id_src_used;
    logic [AW-1:0]       id_rd;
    logic                id_regwrite;
    logic                id_is_load;
    logic                pipe_hold;
    logic                ex_flush;
    logic [NSRC*SW-1:0]  fwd_sel;
    logic                stall_id;
    logic [15:0]         stall_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fwd_hazard_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_src      (id_src),
        .id_src_used (id_src_used),
        .id_rd       (id_rd),
        .id_regwrite (id_regwrite),
        .id_is_load  (id_is_load),
        .pipe_hold   (pipe_hold),
        .ex_flush    (ex_flush),
        .fwd_sel     (fwd_sel),
        .stall_id    (stall_id),
        .stall_cnt   (stall_cnt)
    );

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic v, input logic [AW-1:0] s0, input logic [AW-1:0] s1,
                         input logic [1:0] used, input logic [AW-1:0] rd,
                         input logic rw, input logic ld);
        id_valid    = v;
        id_src      = {s1, s0};
        id_src_used = used;
        id_rd       = rd;
        id_regwrite = rw;
        id_is_load  = ld;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic flush_pipe();
        pipe_hold = 1'b0;
        ex_flush  = 1'b0;
        nop();
        repeat (3) tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b1;
        pipe_hold = 1'b0;
        ex_flush  = 1'b0;
        nop();
        #1 rst_n = 1'b0;
        #1;
        repeat (2) tick();
        checks++;
        if (fwd_sel !== 4'h0) begin
            failures++;
            $display("FAIL reset_fwd_sel actual=%h expected=%h", fwd_sel, 4'h0);
        end
        checks++;
        if (stall_id !== 1'b0) begin
            failures++;
            $display("FAIL reset_stall_id actual=%b expected=%b", stall_id, 1'b0);
        end
        checks++;
        if (stall_cnt !== 16'h0000) begin
            failures++;
            $display("FAIL reset_stall_cnt actual=%h expected=%h", stall_cnt, 16'h0000);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        flush_pipe();
        drive(1'b1, 5'd1, 5'd2, 2'b11, 5'd3, 1'b1, 1'b0);   // add r3
        tick();
        drive(1'b1, 5'd3, 5'd4, 2'b11, 5'd10, 1'b1, 1'b0);  // sub reads r3, r4
        #1;
        checks++;
        if (stall_id !== 1'b0) begin
            failures++;
            $display("FAIL b2b_stall actual=%b expected=%b", stall_id, 1'b0);
        end
        tick();
        checks++;
        if (fwd_sel !== 4'b0001) begin
            failures++;
            $display("FAIL b2b_sel actual=%h expected=%h", fwd_sel, 4'b0001);
        end
    endtask

    task automatic test_shadowing();
        // Two writers of r5 back to back: youngest wins.
        flush_pipe();
        drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd5, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0);
        tick();
        checks++;
        if (fwd_sel !== 4'b0001) begin
            failures++;
            $display("FAIL shadow_youngest actual=%h expected=%h", fwd_sel, 4'b0001);
        end
        // Writer r5, unrelated r6, consumer of r5 and r6.
        flush_pipe();
        drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd6, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd5, 5'd6, 2'b11, 5'd0, 1'b0, 1'b0);
        tick();
        checks++;
        if (fwd_sel !== 4'b0110) begin
            failures++;
            $display("FAIL dist2_sel actual=%h expected=%h", fwd_sel, 4'b0110);
        end
        // Writer r5 three stages back: register file supplies it.
        flush_pipe();
        drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd6, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd11, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd5, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0);
        tick();
        checks++;
        if (fwd_sel !== 4'b0000) begin
            failures++;
            $display("FAIL dist3_sel actual=%h expected=%h", fwd_sel, 4'b0000);
        end
    endtask

    task automatic test_load_use();
        flush_pipe();
        drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b1);   // load r7
        tick();
        drive(1'b1, 5'd7, 5'd0, 2'b01, 5'd12, 1'b1, 1'b0);  // consumer of r7
        #1;
        checks++;
        if (stall_id !== 1'b1) begin
            failures++;
            $display("FAIL ldu_stall_on actual=%b expected=%b", stall_id, 1'b1);
        end
        tick();
        checks++;
        if (stall_id !== 1'b0) begin
            failures++;
            $display("FAIL ldu_stall_off actual=%b expected=%b", stall_id, 1'b0);
        end
        checks++;
        if (fwd_sel !== 4'b0000) begin
            failures++;
            $display("FAIL ldu_bubble_sel actual=%h expected=%h", fwd_sel, 4'b0000);
        end
        checks++;
        if (stall_cnt !== 16'd1) begin
            failures++;
            $display("FAIL ldu_cnt actual=%h expected=%h", stall_cnt, 16'd1);
        end
        tick();
        checks++;
        if (fwd_sel !== 4'b0010) begin
            failures++;
            $display("FAIL ldu_issue_sel actual=%h expected=%h", fwd_sel, 4'b0010);
        end
        // Older load shadowed by a younger ALU writer of r7.
        flush_pipe();
        drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b1);
        tick();
        drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd7, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0);
        #1;
        checks++;
        if (stall_id !== 1'b0) begin
            failures++;
            $display("FAIL shadow_load_stall actual=%b expected=%b", stall_id, 1'b0);
        end
        tick();
        checks++;
        if (fwd_sel !== 4'b0001) begin
            failures++;
            $display("FAIL shadow_load_sel actual=%h expected=%h", fwd_sel, 4'b0001);
        end
    endtask

    task automatic test_zero_unused();
        flush_pipe();
        drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b1, 1'b1);   // load into r0
        tick();
        drive(1'b1, 5'd0, 5'd0, 2'b11, 5'd0, 1'b0, 1'b0);   // reads r0
        #1;
        checks++;
        if (stall_id !== 1'b0) begin
            failures++;
            $display("FAIL r0_stall actual=%b expected=%b", stall_id, 1'b0);
        end
        tick();
        checks++;
        if (fwd_sel !== 4'b0000) begin
            failures++;
            $display("FAIL r0_sel actual=%h expected=%h", fwd_sel, 4'b0000);
        end
        flush_pipe();
        drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b1);   // load r7
        tick();
        drive(1'b1, 5'd7, 5'd7, 2'b00, 5'd0, 1'b0, 1'b0);   // unused operands
        #1;
        checks++;
        if (stall_id !== 1'b0) begin
            failures++;
            $display("FAIL unused_stall actual=%b expected=%b", stall_id, 1'b0);
        end
        drive(1'b0, 5'd7, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0);   // invalid ID
        #1;
        checks++;
        if (stall_id !== 1'b0) begin
            failures++;
            $display("FAIL invalid_stall actual=%b expected=%b", stall_id, 1'b0);
        end
        drive(1'b1, 5'd7, 5'd7, 2'b00, 5'd0, 1'b0, 1'b0);
        #1;
        tick();
        checks++;
        if (fwd_sel !== 4'b0000) begin
            failures++;
            $display("FAIL unused_sel actual=%h expected=%h", fwd_sel, 4'b0000);
        end
    endtask

    task automatic test_hold_flush();
        flush_pipe();
        drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd2, 1'b1, 1'b0);   // alu r2
        tick();
        drive(1'b1, 5'd2, 5'd0, 2'b01, 5'd8, 1'b1, 1'b1);   // load r8 using r2
        tick();
        drive(1'b1, 5'd0, 5'd8, 2'b10, 5'd0, 1'b0, 1'b0);   // consumer r8 on op1
        #1;
        checks++;
        if (stall_id !== 1'b1) begin
            failures++;
            $display("FAIL hold_stall_pre actual=%b expected=%b", stall_id, 1'b1);
        end
        pipe_hold = 1'b1;
        ex_flush  = 1'b1;
        for (int n = 0; n < 3; n++) begin
            tick();
            checks++;
            if ({stall_id, fwd_sel, stall_cnt} !== {1'b1, 4'b0001, 16'd1}) begin
                failures++;
                $display("FAIL hold_frozen cycle=%0d actual=%b/%h/%h expected=1/1/0001",
                         n, stall_id, fwd_sel, stall_cnt);
            end
        end
        pipe_hold = 1'b0;
        ex_flush  = 1'b0;
        tick();
        checks++;
        if ({stall_id, fwd_sel, stall_cnt} !== {1'b0, 4'b0000, 16'd2}) begin
            failures++;
            $display("FAIL hold_release actual=%b/%h/%h expected=0/0/0002",
                     stall_id, fwd_sel, stall_cnt);
        end
        tick();
        checks++;
        if (fwd_sel !== 4'b1000) begin
            failures++;
            $display("FAIL hold_issue_sel actual=%h expected=%h", fwd_sel, 4'b1000);
        end
        // Flushed writer r9 must not be forwarded.
        flush_pipe();
        drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd2, 1'b1, 1'b0);   // alu r2
        tick();
        drive(1'b1, 5'd2, 5'd0, 2'b01, 5'd9, 1'b1, 1'b0);   // alu r9, flushed
        ex_flush = 1'b1;
        tick();
        ex_flush = 1'b0;
        checks++;
        if (fwd_sel !== 4'b0000) begin
            failures++;
            $display("FAIL flush_sel actual=%h expected=%h", fwd_sel, 4'b0000);
        end
        drive(1'b1, 5'd9, 5'd2, 2'b11, 5'd0, 1'b0, 1'b0);
        tick();
        checks++;
        if (fwd_sel !== 4'b1000) begin
            failures++;
            $display("FAIL flush_consumer_sel actual=%h expected=%h", fwd_sel, 4'b1000);
        end
    endtask

    task automatic test_saturation();
        flush_pipe();
        force dut.stall_cnt_q = 16'hFFFE;
        #1;
        release dut.stall_cnt_q;
        #1;
        for (int n = 0; n < 3; n++) begin
            drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b1);
            tick();
            drive(1'b1, 5'd7, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0);
            tick();
            checks++;
            if (stall_cnt !== 16'hFFFF) begin
                failures++;
                $display("FAIL sat_cnt round=%0d actual=%h expected=%h", n, stall_cnt, 16'hFFFF);
            end
        end
    endtask

    task automatic test_async_reset();
        flush_pipe();
        drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd2, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd2, 5'd0, 2'b01, 5'd7, 1'b1, 1'b1);   // load r7 using r2
        tick();
        drive(1'b1, 5'd7, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0);
        #1;
        checks++;
        if ({stall_id, fwd_sel} !== {1'b1, 4'b0001}) begin
            failures++;
            $display("FAIL arst_pre actual=%b/%h expected=1/1", stall_id, fwd_sel);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({stall_id, fwd_sel, stall_cnt} !== {1'b0, 4'b0000, 16'h0000}) begin
            failures++;
            $display("FAIL arst_immediate actual=%b/%h/%h expected=0/0/0000",
                     stall_id, fwd_sel, stall_cnt);
        end
        #1 rst_n = 1'b1;
        nop();
        tick();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_shadowing();
        test_load_use();
        test_zero_unused();
        test_hold_flush();
        test_saturation();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
